// File: rtl/mips_lite_core.sv
`default_nettype none
// ============================================================================
// Module   : mips_lite_core
// Brief    : Single-cycle 32-bit MIPS-subset core with a unified big-endian
//            memory and a host access port. Define PROCESSOR_HALT_EN to add
//            BREAK support and the sticky 'halted' output.
// Revision : 1.0 - initial release
// ============================================================================
module mips_lite_core #(
   parameter int          MEM_WORDS = 32768,
   parameter logic [31:0] RESET_PC  = 32'h0000_0400
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pause,
   input  logic        externalMemoryControl,
   input  logic [31:0] externalAddress,
   input  logic [31:0] externalData,
   input  logic [2:0]  externalReadMode,
   input  logic [2:0]  externalWriteMode,
   output logic [31:0] externalDataOut
`ifdef PROCESSOR_HALT_EN
   ,
   output logic        halted
`endif
);

   localparam int         c_IDX_BITS     = $clog2(MEM_WORDS);
   localparam logic [2:0] c_MODE_NONE    = 3'd0;
   localparam logic [2:0] c_MODE_BYTE    = 3'd1;
   localparam logic [2:0] c_MODE_BYTE_U  = 3'd2;
   localparam logic [2:0] c_MODE_HALF    = 3'd3;
   localparam logic [2:0] c_MODE_HALF_U  = 3'd4;
   localparam logic [2:0] c_MODE_WORD    = 3'd5;

   // Big-endian extraction: byte offset 0 lives in bits 31:24.
   function automatic logic [31:0] f_readExtract(input logic [31:0] word,
                                                 input logic [1:0]  offset,
                                                 input logic [2:0]  mode);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] result;
      b = word[{~offset, 3'b000} +: 8];
      h = offset[1] ? word[15:0] : word[31:16];
      case (mode)
         c_MODE_BYTE:   result = {{24{b[7]}}, b};
         c_MODE_BYTE_U: result = {24'h0, b};
         c_MODE_HALF:   result = {{16{h[15]}}, h};
         c_MODE_HALF_U: result = {16'h0, h};
         c_MODE_WORD:   result = word;
         default:       result = 32'h0;
      endcase
      return result;
   endfunction

   logic [31:0] r_mem [MEM_WORDS];
   logic [31:0] r_regs [32];
   logic [31:0] r_pc;

   logic [31:0] w_instr;
   logic [5:0]  w_opcode;
   logic [5:0]  w_funct;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   logic [4:0]  w_shamt;
   logic [15:0] w_imm;
   logic [25:0] w_target;
   logic [31:0] w_simm;
   logic [31:0] w_zimm;
   logic [31:0] w_rsVal;
   logic [31:0] w_rtVal;
   logic [31:0] w_pcPlus4;
   logic [31:0] w_branchTarget;
   logic [31:0] w_memAddr;
   logic [31:0] w_dataAddr;
   logic [c_IDX_BITS-1:0] w_memIdx;
   logic [31:0] w_dataWord;
   logic [31:0] w_loadData;
   logic [2:0]  w_loadMode;
   logic [2:0]  w_storeMode;
   logic        w_run;
   logic [31:0] w_nextPc;
   logic        w_regWe;
   logic [4:0]  w_regDst;
   logic [31:0] w_regWData;
   logic        w_wrExt;
   logic        w_wrCore;
   logic        w_memWe;
   logic [2:0]  w_wrMode;
   logic [31:0] w_wrData;
   logic [3:0]  w_byteEn;
   logic [31:0] w_wrWord;
   logic        w_unusedBits;

   assign w_instr        = r_mem[r_pc[c_IDX_BITS+1:2]];
   assign w_opcode       = w_instr[31:26];
   assign w_rs           = w_instr[25:21];
   assign w_rt           = w_instr[20:16];
   assign w_rd           = w_instr[15:11];
   assign w_shamt        = w_instr[10:6];
   assign w_funct        = w_instr[5:0];
   assign w_imm          = w_instr[15:0];
   assign w_target       = w_instr[25:0];
   assign w_simm         = {{16{w_imm[15]}}, w_imm};
   assign w_zimm         = {16'h0, w_imm};
   assign w_rsVal        = (w_rs == 5'd0) ? 32'h0 : r_regs[w_rs];
   assign w_rtVal        = (w_rt == 5'd0) ? 32'h0 : r_regs[w_rt];
   assign w_pcPlus4      = r_pc + 32'd4;
   assign w_branchTarget = w_pcPlus4 + {w_simm[29:0], 2'b00};
   assign w_memAddr      = w_rsVal + w_simm;

   // The single data port belongs to the host whenever it holds the memory.
   assign w_dataAddr     = externalMemoryControl ? externalAddress : w_memAddr;
   assign w_memIdx       = w_dataAddr[c_IDX_BITS+1:2];
   assign w_dataWord     = r_mem[w_memIdx];
   assign w_loadData     = f_readExtract(w_dataWord, w_dataAddr[1:0], w_loadMode);
   assign w_unusedBits   = ^{w_dataAddr[31:c_IDX_BITS+2]};

   assign externalDataOut = externalMemoryControl ?
                            f_readExtract(w_dataWord, externalAddress[1:0], externalReadMode) : 32'h0;

   always_comb begin
      w_loadMode  = c_MODE_NONE;
      w_storeMode = c_MODE_NONE;
      case (w_opcode)
         6'h20:   w_loadMode  = c_MODE_BYTE;
         6'h24:   w_loadMode  = c_MODE_BYTE_U;
         6'h21:   w_loadMode  = c_MODE_HALF;
         6'h25:   w_loadMode  = c_MODE_HALF_U;
         6'h23:   w_loadMode  = c_MODE_WORD;
         6'h28:   w_storeMode = c_MODE_BYTE;
         6'h29:   w_storeMode = c_MODE_HALF;
         6'h2B:   w_storeMode = c_MODE_WORD;
         default: ;
      endcase
   end

   always_comb begin
      w_nextPc   = w_pcPlus4;
      w_regWe    = 1'b0;
      w_regDst   = w_rt;
      w_regWData = 32'h0;
      case (w_opcode)
         6'h00: begin
            w_regDst = w_rd;
            w_regWe  = 1'b1;
            case (w_funct)
               6'h00: w_regWData = w_rtVal << w_shamt;
               6'h02: w_regWData = w_rtVal >> w_shamt;
               6'h03: w_regWData = $signed(w_rtVal) >>> w_shamt;
               6'h04: w_regWData = w_rtVal << w_rsVal[4:0];
               6'h06: w_regWData = w_rtVal >> w_rsVal[4:0];
               6'h07: w_regWData = $signed(w_rtVal) >>> w_rsVal[4:0];
               6'h08: begin
                  w_regWe  = 1'b0;
                  w_nextPc = w_rsVal;
               end
               6'h09: begin
                  w_regWData = w_pcPlus4;
                  w_nextPc   = w_rsVal;
               end
               6'h20, 6'h21: w_regWData = w_rsVal + w_rtVal;
               6'h22, 6'h23: w_regWData = w_rsVal - w_rtVal;
               6'h24: w_regWData = w_rsVal & w_rtVal;
               6'h25: w_regWData = w_rsVal | w_rtVal;
               6'h26: w_regWData = w_rsVal ^ w_rtVal;
               6'h27: w_regWData = ~(w_rsVal | w_rtVal);
               6'h2A: w_regWData = {31'h0, $signed(w_rsVal) < $signed(w_rtVal)};
               6'h2B: w_regWData = {31'h0, w_rsVal < w_rtVal};
`ifdef PROCESSOR_HALT_EN
               6'h0D: begin
                  w_regWe  = 1'b0;
                  w_nextPc = r_pc;
               end
`endif
               default: w_regWe = 1'b0;
            endcase
         end
         6'h02: w_nextPc = {w_pcPlus4[31:28], w_target, 2'b00};
         6'h03: begin
            w_nextPc   = {w_pcPlus4[31:28], w_target, 2'b00};
            w_regWe    = 1'b1;
            w_regDst   = 5'd31;
            w_regWData = w_pcPlus4;
         end
         6'h04: if (w_rsVal == w_rtVal) w_nextPc = w_branchTarget;
         6'h05: if (w_rsVal != w_rtVal) w_nextPc = w_branchTarget;
         6'h06: if ($signed(w_rsVal) <= 32'sd0) w_nextPc = w_branchTarget;
         6'h07: if ($signed(w_rsVal) > 32'sd0) w_nextPc = w_branchTarget;
         6'h08, 6'h09: begin
            w_regWe    = 1'b1;
            w_regWData = w_rsVal + w_simm;
         end
         6'h0A: begin
            w_regWe    = 1'b1;
            w_regWData = {31'h0, $signed(w_rsVal) < $signed(w_simm)};
         end
         6'h0B: begin
            w_regWe    = 1'b1;
            w_regWData = {31'h0, w_rsVal < w_simm};
         end
         6'h0C: begin
            w_regWe    = 1'b1;
            w_regWData = w_rsVal & w_zimm;
         end
         6'h0D: begin
            w_regWe    = 1'b1;
            w_regWData = w_rsVal | w_zimm;
         end
         6'h0E: begin
            w_regWe    = 1'b1;
            w_regWData = w_rsVal ^ w_zimm;
         end
         6'h0F: begin
            w_regWe    = 1'b1;
            w_regWData = {w_imm, 16'h0};
         end
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
            w_regWe    = 1'b1;
            w_regWData = w_loadData;
         end
         default: ;
      endcase
   end

   // Host writes win and remain active during reset; core writes need a live core.
   assign w_wrExt  = externalMemoryControl && (externalWriteMode >= c_MODE_BYTE) &&
                     (externalWriteMode <= c_MODE_WORD);
   assign w_wrCore = rst && w_run && (w_storeMode != c_MODE_NONE);
   assign w_memWe  = w_wrExt || w_wrCore;
   assign w_wrMode = w_wrExt ? externalWriteMode : w_storeMode;
   assign w_wrData = w_wrExt ? externalData : w_rtVal;

   always_comb begin
      w_byteEn = 4'b0000;
      w_wrWord = 32'h0;
      case (w_wrMode)
         c_MODE_BYTE, c_MODE_BYTE_U: begin
            w_byteEn = 4'b1000 >> w_dataAddr[1:0];
            w_wrWord = {4{w_wrData[7:0]}};
         end
         c_MODE_HALF, c_MODE_HALF_U: begin
            w_byteEn = w_dataAddr[1] ? 4'b0011 : 4'b1100;
            w_wrWord = {2{w_wrData[15:0]}};
         end
         c_MODE_WORD: begin
            w_byteEn = 4'b1111;
            w_wrWord = w_wrData;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_memWe) begin
         for (int b = 0; b < 4; b++) begin
            if (w_byteEn[b]) r_mem[w_memIdx][b*8 +: 8] <= w_wrWord[b*8 +: 8];
         end
      end
   end

`ifdef PROCESSOR_HALT_EN
   logic r_halted;
   logic w_isBreak;

   assign w_isBreak = (w_opcode == 6'h00) && (w_funct == 6'h0D);
   assign w_run     = !pause && !externalMemoryControl && !r_halted;
   assign halted    = r_halted;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_halted <= 1'b0;
      end else if (w_run && w_isBreak) begin
         r_halted <= 1'b1;
      end
   end
`else
   assign w_run = !pause && !externalMemoryControl;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc <= RESET_PC;
         for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
      end else if (w_run) begin
         r_pc <= w_nextPc;
         if (w_regWe && (w_regDst != 5'd0)) r_regs[w_regDst] <= w_regWData;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mips_lite_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_lite_core
// Brief    : Self-checking bench for mips_lite_core: directed programs plus
//            random programs compared against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_lite_core;

   localparam int MEM_BYTES = 32768 * 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        pause;
   logic        externalMemoryControl;
   logic [31:0] externalAddress;
   logic [31:0] externalData;
   logic [2:0]  externalReadMode;
   logic [2:0]  externalWriteMode;
   logic [31:0] externalDataOut;
`ifdef PROCESSOR_HALT_EN
   logic        halted;
`endif

   mips_lite_core dut (
      .clk                   (clk),
      .rst                   (rst),
      .pause                 (pause),
      .externalMemoryControl (externalMemoryControl),
      .externalAddress       (externalAddress),
      .externalData          (externalData),
      .externalReadMode      (externalReadMode),
      .externalWriteMode     (externalWriteMode),
      .externalDataOut       (externalDataOut)
`ifdef PROCESSOR_HALT_EN
      ,
      .halted                (halted)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   // ---------------- reference model: byte memory + ISA interpreter ----------
   bit [7:0]  mMem [int unsigned];
   bit [31:0] mReg [32];
   bit [31:0] mPc;

   function automatic bit [7:0] mByte(input bit [31:0] a);
      int unsigned k = a % MEM_BYTES;
      return mMem.exists(k) ? mMem[k] : 8'h00;
   endfunction

   function automatic bit [31:0] mLoad(input bit [31:0] a, input int mode);
      bit [7:0]  b = mByte(a);
      bit [31:0] hb = a & ~32'd1;
      bit [31:0] wb = a & ~32'd3;
      bit [15:0] h = {mByte(hb), mByte(hb + 1)};
      case (mode)
         1: return {{24{b[7]}}, b};
         2: return {24'h0, b};
         3: return {{16{h[15]}}, h};
         4: return {16'h0, h};
         5: return {mByte(wb), mByte(wb + 1), mByte(wb + 2), mByte(wb + 3)};
         default: return 32'h0;
      endcase
   endfunction

   task automatic mStore(input bit [31:0] a, input bit [31:0] v, input int mode);
      bit [31:0] hb = a & ~32'd1;
      bit [31:0] wb = a & ~32'd3;
      case (mode)
         1, 2: mMem[a % MEM_BYTES] = v[7:0];
         3, 4: begin
            mMem[hb % MEM_BYTES]       = v[15:8];
            mMem[(hb + 1) % MEM_BYTES] = v[7:0];
         end
         5: for (int i = 0; i < 4; i++) mMem[(wb + i) % MEM_BYTES] = v[31 - 8*i -: 8];
         default: ;
      endcase
   endtask

   task automatic mReset();
      mPc = 32'h400;
      for (int i = 0; i < 32; i++) mReg[i] = 32'h0;
   endtask

   task automatic mStep();
      bit [31:0] ins, a, b, simm, zimm, npc, val;
      bit [5:0]  op, fn;
      bit [4:0]  dst;
      bit        wr;
      ins  = mLoad(mPc, 5);
      op   = ins[31:26];
      fn   = ins[5:0];
      a    = mReg[ins[25:21]];
      b    = mReg[ins[20:16]];
      simm = {{16{ins[15]}}, ins[15:0]};
      zimm = {16'h0, ins[15:0]};
      npc  = mPc + 4;
      wr   = 1'b1;
      dst  = ins[20:16];
      val  = 32'h0;
      case (op)
         6'h00: begin
            dst = ins[15:11];
            case (fn)
               6'h00: val = b << ins[10:6];
               6'h02: val = b >> ins[10:6];
               6'h03: val = $signed(b) >>> ins[10:6];
               6'h04: val = b << a[4:0];
               6'h06: val = b >> a[4:0];
               6'h07: val = $signed(b) >>> a[4:0];
               6'h08: begin wr = 1'b0; npc = a; end
               6'h09: begin val = mPc + 4; npc = a; end
               6'h20, 6'h21: val = a + b;
               6'h22, 6'h23: val = a - b;
               6'h24: val = a & b;
               6'h25: val = a | b;
               6'h26: val = a ^ b;
               6'h27: val = ~(a | b);
               6'h2A: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               6'h2B: val = (a < b) ? 32'd1 : 32'd0;
               default: wr = 1'b0;
            endcase
         end
         6'h02: begin wr = 1'b0; npc = {npc[31:28], ins[25:0], 2'b00}; end
         6'h03: begin dst = 5'd31; val = mPc + 4; npc = {npc[31:28], ins[25:0], 2'b00}; end
         6'h04: begin wr = 1'b0; if (a == b) npc = mPc + 4 + (simm << 2); end
         6'h05: begin wr = 1'b0; if (a != b) npc = mPc + 4 + (simm << 2); end
         6'h06: begin wr = 1'b0; if ($signed(a) <= 0) npc = mPc + 4 + (simm << 2); end
         6'h07: begin wr = 1'b0; if ($signed(a) > 0) npc = mPc + 4 + (simm << 2); end
         6'h08, 6'h09: val = a + simm;
         6'h0A: val = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0;
         6'h0B: val = (a < simm) ? 32'd1 : 32'd0;
         6'h0C: val = a & zimm;
         6'h0D: val = a | zimm;
         6'h0E: val = a ^ zimm;
         6'h0F: val = {ins[15:0], 16'h0};
         6'h20: val = mLoad(a + simm, 1);
         6'h24: val = mLoad(a + simm, 2);
         6'h21: val = mLoad(a + simm, 3);
         6'h25: val = mLoad(a + simm, 4);
         6'h23: val = mLoad(a + simm, 5);
         6'h28: begin wr = 1'b0; mStore(a + simm, b, 1); end
         6'h29: begin wr = 1'b0; mStore(a + simm, b, 3); end
         6'h2B: begin wr = 1'b0; mStore(a + simm, b, 5); end
         default: wr = 1'b0;
      endcase
      if (wr && dst != 5'd0) mReg[dst] = val;
      mPc = npc;
   endtask

   // ---------------- encoders ------------------------------------------------
   function automatic bit [31:0] rType(input int rs, input int rt, input int rd, input int sh, input int fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction
   function automatic bit [31:0] iType(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction
   function automatic bit [31:0] jType(input int op, input int addr);
      return {6'(op), 26'(addr >> 2)};
   endfunction

   function automatic bit [31:0] randInstr();
      bit [5:0] rFn [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                             6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
      bit [5:0] iOp [8]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
      bit [5:0] ldOp [5] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
      bit [5:0] stOp [3] = '{6'h28, 6'h29, 6'h2B};
      bit [5:0] brOp [4] = '{6'h04, 6'h05, 6'h06, 6'h07};
      int k  = $urandom_range(0, 9);
      int rs = $urandom_range(0, 31);
      int rt = $urandom_range(0, 31);
      int rd = $urandom_range(0, 31);
      int sh = $urandom_range(0, 31);
      case (k)
         0, 1, 2: return rType(rs, rt, rd, sh, rFn[$urandom_range(0, 15)]);
         3, 4:    return iType(iOp[$urandom_range(0, 7)], rs, rt, $urandom_range(0, 65535));
         5, 6:    return iType(ldOp[$urandom_range(0, 4)], 0, rt, 'h5000 + $urandom_range(0, 255));
         7:       return iType(stOp[$urandom_range(0, 2)], 0, rt, 'h5000 + $urandom_range(0, 255));
         8:       return iType(brOp[$urandom_range(0, 3)], rs, rt, $urandom_range(0, 2));
         default: return ($urandom_range(0, 1) == 0) ? {6'h3F, 26'($urandom)} : rType(rs, rt, rd, sh, 'h3E);
      endcase
   endfunction

   // ---------------- DUT access tasks ----------------------------------------
   task automatic extWrite(input bit [31:0] a, input bit [31:0] d, input bit [2:0] mode);
      @(negedge clk);
      externalMemoryControl = 1'b1;
      externalAddress       = a;
      externalData          = d;
      externalWriteMode     = mode;
      @(posedge clk);
      #1 externalWriteMode  = 3'd0;
      mStore(a, d, int'(mode));
   endtask

   task automatic extRead(input bit [31:0] a, input bit [2:0] mode, output logic [31:0] d);
      @(negedge clk);
      externalMemoryControl = 1'b1;
      externalAddress       = a;
      externalReadMode      = mode;
      #1 d = externalDataOut;
      externalReadMode      = 3'd0;
   endtask

   task automatic checkWord(input string tag, input bit [31:0] a, input bit [31:0] exp);
      logic [31:0] d;
      extRead(a, 3'd5, d);
      checkVal(tag, d, exp);
   endtask

   task automatic loadProgram(input bit [31:0] prog [$]);
      @(negedge clk);
      rst = 1'b0;
      foreach (prog[i]) extWrite(32'h400 + 4*i, prog[i], 3'd5);
      mReset();
   endtask

   task automatic runCycles(input int n);
      @(negedge clk);
      rst = 1'b1;
      pause = 1'b0;
      externalMemoryControl = 1'b0;
      repeat (n) begin
         @(posedge clk);
         mStep();
      end
      @(negedge clk);
      externalMemoryControl = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [31:0]   p [$];
      logic [31:0] d;

      rst = 1'b0; pause = 1'b0; externalMemoryControl = 1'b0;
      externalAddress = 32'h400; externalData = 32'h0;
      externalReadMode = 3'd0; externalWriteMode = 3'd0;
      mReset();
      repeat (2) @(negedge clk);
      externalReadMode = 3'd5;
      #1 checkVal("rstDataOut", externalDataOut, 32'h0);
      externalReadMode = 3'd0;

      // host port: modes, byte-granular writes, address wrap, invalid modes
      extWrite(32'd1024, 32'h1234_5678, 3'd5);
      checkWord("extWord", 32'd1024, 32'h1234_5678);
      extRead(32'd1025, 3'd1, d);  checkVal("extByte1025", d, 32'h0000_0034);
      extRead(32'd1027, 3'd4, d);  checkVal("extHalfU1027", d, 32'h0000_5678);
      extWrite(32'd1027, 32'hFFFF_FF80, 3'd1);
      extRead(32'd1027, 3'd2, d);  checkVal("extByteU80", d, 32'h0000_0080);
      extRead(32'd1027, 3'd1, d);  checkVal("extByteS80", d, 32'hFFFF_FF80);
      checkWord("extByteMerge", 32'd1024, 32'h1234_5680);
      extRead(32'd1024, 3'd6, d);  checkVal("extMode6", d, 32'h0);
      extWrite(32'd1024, 32'h0, 3'd7);
      checkWord("extWrMode7", 32'd1024, 32'h1234_5680);
      extWrite(32'h0002_0100, 32'hCAFE_F00D, 3'd5);
      checkWord("extWrap", 32'h0000_0100, 32'hCAFE_F00D);

      // ALU
      p = {iType('h09, 0, 1, 5), iType('h09, 0, 2, -3), rType(1, 2, 3, 0, 'h21),
           iType('h2B, 0, 3, 20000), jType('h02, 1040)};
      loadProgram(p); runCycles(10);
      checkWord("aluAddu", 32'd20000, 32'h0000_0002);

      // sum 1..10 with a BNE loop
      p = {iType('h09, 0, 1, 10), iType('h09, 0, 2, 0), rType(2, 1, 2, 0, 'h21),
           iType('h09, 1, 1, -1), iType('h05, 1, 0, -3), iType('h2B, 0, 2, 20004),
           jType('h02, 1048)};
      loadProgram(p); runCycles(50);
      checkWord("loopSum", 32'd20004, 32'd55);

      // JAL / JALR round trip
      p = {32'h0, 32'h0, 32'h0, 32'h0, jType('h03, 1056), iType('h2B, 0, 31, 20008),
           iType('h2B, 0, 30, 20032), jType('h02, 1052), rType(31, 0, 30, 0, 'h09)};
      loadProgram(p); runCycles(20);
      checkWord("jalRa", 32'd20008, 32'h0000_0414);
      checkWord("jalrRd", 32'd20032, 32'h0000_0424);

      // sub-word stores and loads
      extWrite(32'd20012, 32'h0, 3'd5);
      p = {iType('h09, 0, 1, 'hAB), iType('h28, 0, 1, 20013), iType('h0D, 0, 2, 'hCDEF),
           iType('h29, 0, 2, 20014), iType('h23, 0, 3, 20012), iType('h21, 0, 4, 20014),
           iType('h25, 0, 5, 20014), iType('h2B, 0, 3, 20040), iType('h2B, 0, 4, 20044),
           iType('h2B, 0, 5, 20048), jType('h02, 1064)};
      loadProgram(p); runCycles(20);
      checkWord("subLw", 32'd20040, 32'h00AB_CDEF);
      checkWord("subLh", 32'd20044, 32'hFFFF_CDEF);
      checkWord("subLhu", 32'd20048, 32'h0000_CDEF);

      // compares and shifts
      p = {iType('h0F, 0, 1, 'h8000), iType('h09, 0, 2, -1), iType('h09, 0, 3, 1),
           rType(2, 3, 4, 0, 'h2A), rType(2, 3, 5, 0, 'h2B), rType(0, 1, 6, 4, 'h03),
           rType(0, 1, 7, 4, 'h02), iType('h2B, 0, 4, 20016), iType('h2B, 0, 5, 20020),
           iType('h2B, 0, 6, 20024), iType('h2B, 0, 7, 20028), jType('h02, 1068)};
      loadProgram(p); runCycles(20);
      checkWord("slt", 32'd20016, 32'h1);
      checkWord("sltu", 32'd20020, 32'h0);
      checkWord("sra", 32'd20024, 32'hF800_0000);
      checkWord("srl", 32'd20028, 32'h0800_0000);

      // pause hold, resume at held PC, asynchronous reset pulse
      p = {iType('h09, 5, 5, 1), iType('h2B, 0, 5, 20000), iType('h04, 0, 0, -3)};
      loadProgram(p); runCycles(20);
      checkWord("pauseBefore", 32'd20000, 32'd7);
      @(negedge clk);
      pause = 1'b1;
      externalMemoryControl = 1'b0;
      repeat (100) @(posedge clk);
      @(negedge clk);
      externalMemoryControl = 1'b1;
      checkWord("pauseHeld", 32'd20000, mLoad(32'd20000, 5));
      checkWord("pauseHeldConst", 32'd20000, 32'd7);
      runCycles(3);
      checkWord("pauseResume", 32'd20000, 32'd8);
      @(negedge clk);
      externalMemoryControl = 1'b0;
      #2 rst = 1'b0;
      #2 rst = 1'b1;
      mReset();
      repeat (2) begin
         @(posedge clk);
         mStep();
      end
      @(negedge clk);
      externalMemoryControl = 1'b1;
      checkWord("asyncReset", 32'd20000, 32'd1);
      checkWord("asyncResetModel", 32'd20000, mLoad(32'd20000, 5));

      // random programs against the model
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < 64; i++) extWrite(32'h5000 + 4*i, $urandom, 3'd5);
         for (int i = 0; i < 32; i++) extWrite(32'h6000 + 4*i, $urandom, 3'd5);
         p = {};
         for (int i = 0; i < 40; i++) p.push_back(randInstr());
         for (int r = 1; r < 32; r++) p.push_back(iType('h2B, 0, r, 'h6000 + 4*r));
         p.push_back(jType('h02, 32'h400 + 4*p.size()));
         loadProgram(p);
         runCycles(90);
         for (int i = 0; i < 64; i++)
            checkWord($sformatf("rnd%0d_data%0d", t, i), 32'h5000 + 4*i, mLoad(32'h5000 + 4*i, 5));
         for (int i = 0; i < 32; i++)
            checkWord($sformatf("rnd%0d_reg%0d", t, i), 32'h6000 + 4*i, mLoad(32'h6000 + 4*i, 5));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
